// File: rtl/uart_receiver.sv
// UART receiver: 2-flop synchronized serial input, mid-bit sampling, optional parity,
// framing-error detection with a break state that waits for the line to return high.
module uart_receiver #(
    parameter int unsigned DATA_LENGTH  = 8,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned CLKS_PER_BIT = 20
) (
    input  logic                   tx_clk,
    input  logic                   rst,
    input  logic                   serial_in,
    input  logic                   parity_type,
    output logic [DATA_LENGTH-1:0] data_out,
    output logic                   data_valid,
    output logic                   parity_err,
    output logic                   frame_err,
    output logic                   busy
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W = $clog2(DATA_LENGTH + 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_LENGTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } state_t;

    state_t                   state;
    logic                     sync_meta;
    logic                     rxs;
    logic                     rxs_d;
    logic [CNT_W-1:0]         cnt;
    logic [BIT_W-1:0]         bit_cnt;
    logic [DATA_LENGTH-1:0]   shift;
    logic                     par_bad;
    logic                     par_calc;

    always_ff @(posedge tx_clk or posedge rst) begin
        if (rst) begin
            sync_meta <= 1'b1;
            rxs       <= 1'b1;
            rxs_d     <= 1'b1;
        end else begin
            sync_meta <= serial_in;
            rxs       <= sync_meta;
            rxs_d     <= rxs;
        end
    end

    always_comb begin
        par_calc = parity_type ? ~^shift : ^shift;
    end

    // cnt restarts at every sample point, so each sample lands one full bit after the last.
    always_ff @(posedge tx_clk or posedge rst) begin
        if (rst) begin
            state      <= StIdle;
            cnt        <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            par_bad    <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (rxs_d && !rxs) begin
                        state   <= StStart;
                        cnt     <= '0;
                        bit_cnt <= '0;
                    end
                end
                StStart: begin
                    if (cnt == CNT_HALF) begin
                        cnt   <= '0;
                        state <= rxs ? StIdle : StData;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                StData: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        shift <= {rxs, shift[DATA_LENGTH-1:1]};
                        if (bit_cnt == BIT_LAST) begin
                            state <= (PARITY_EN != 0) ? StParity : StStop;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                StParity: begin
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        par_bad <= (rxs != par_calc);
                        state   <= StStop;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                StStop: begin
                    if (cnt == CNT_LAST) begin
                        cnt        <= '0;
                        data_out   <= shift;
                        data_valid <= 1'b1;
                        parity_err <= (PARITY_EN != 0) ? par_bad : 1'b0;
                        frame_err  <= !rxs;
                        state      <= rxs ? StIdle : StBreak;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                StBreak: begin
                    if (rxs) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign busy = (state != StIdle);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: 8N1 instance plus an 8-bit even/odd parity instance.
`timescale 1ns/1ps
module tb_uart_receiver;

    localparam int C = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       line0 = 1'b1;
    logic       line1 = 1'b1;
    logic       ptype0 = 1'b0;
    logic       ptype1 = 1'b0;
    logic [7:0] dout0, dout1;
    logic       dv0, dv1, perr0, perr1, ferr0, ferr1, busy0, busy1;

    always #5 clk = ~clk;

    uart_receiver #(.DATA_LENGTH(8), .PARITY_EN(0), .CLKS_PER_BIT(C)) dut (
        .tx_clk(clk), .rst(rst), .serial_in(line0), .parity_type(ptype0),
        .data_out(dout0), .data_valid(dv0), .parity_err(perr0), .frame_err(ferr0),
        .busy(busy0)
    );

    uart_receiver #(.DATA_LENGTH(8), .PARITY_EN(1), .CLKS_PER_BIT(C)) dut_p (
        .tx_clk(clk), .rst(rst), .serial_in(line1), .parity_type(ptype1),
        .data_out(dout1), .data_valid(dv1), .parity_err(perr1), .frame_err(ferr1),
        .busy(busy1)
    );

    typedef struct {
        logic [7:0]  data;
        logic        perr;
        logic        ferr;
        int unsigned cyc;
    } rec_t;

    typedef struct {
        bit          sel;
        logic [7:0]  d;
        logic        pbit;
        logic        ptype;
        logic [7:0]  exp_d;
        logic        exp_perr;
        logic        exp_ferr;
        int unsigned exp_lat;
    } vec_t;

    rec_t        q0[$];
    rec_t        q1[$];
    int unsigned cyc = 0;
    int          dbl0 = 0;
    int          dbl1 = 0;
    logic        dv0_prev = 1'b0;
    logic        dv1_prev = 1'b0;
    int          total = 0;
    int          bad = 0;

    always @(posedge clk) cyc++;

    // Record every data_valid cycle; a high level on two consecutive cycles is a stretched pulse.
    always @(negedge clk) begin
        rec_t r;
        if (dv0) begin
            r.data = dout0; r.perr = perr0; r.ferr = ferr0; r.cyc = cyc;
            q0.push_back(r);
            if (dv0_prev) dbl0++;
        end
        if (dv1) begin
            r.data = dout1; r.perr = perr1; r.ferr = ferr1; r.cyc = cyc;
            q1.push_back(r);
            if (dv1_prev) dbl1++;
        end
        dv0_prev = dv0;
        dv1_prev = dv1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input bit sel, input logic v, input int n);
        if (sel) line1 = v;
        else     line0 = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input bit use_par,
                              input logic pbit, input logic sbit);
        drive_bit(sel, 1'b0, C);
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i], C);
        if (use_par) drive_bit(sel, pbit, C);
        drive_bit(sel, sbit, C);
    endtask

    vec_t        vecs[7];
    int unsigned t0;
    int unsigned n;
    rec_t        r;

    initial begin
        // Line fall -> 2 sync flops -> edge detect (t=0) -> stop sample t=190: seen 193 negedges on.
        vecs[0] = '{1'b0, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 193};
        vecs[1] = '{1'b0, 8'h01, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 193};
        vecs[2] = '{1'b1, 8'h03, 1'b1, 1'b0, 8'h03, 1'b1, 1'b0, 213};
        vecs[3] = '{1'b1, 8'h03, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 213};
        vecs[4] = '{1'b1, 8'h03, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 213};
        vecs[5] = '{1'b1, 8'h80, 1'b1, 1'b0, 8'h80, 1'b0, 1'b0, 213};
        vecs[6] = '{1'b1, 8'h80, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0, 213};

        repeat (3) @(negedge clk);
        check("reset data_out", 32'(dout0), 32'h0);
        check("reset data_valid", 32'(dv0), 32'h0);
        check("reset parity_err", 32'(perr0), 32'h0);
        check("reset frame_err", 32'(ferr0), 32'h0);
        check("reset busy", 32'(busy0), 32'h0);
        check("reset busy par", 32'(busy1), 32'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            q0.delete();
            q1.delete();
            ptype1 = vecs[i].ptype;
            t0 = cyc;
            send_frame(vecs[i].sel, vecs[i].d, vecs[i].sel, vecs[i].pbit, 1'b1);
            repeat (10) @(negedge clk);
            n = vecs[i].sel ? q1.size() : q0.size();
            check($sformatf("vec%0d valid count", i), n, 32'd1);
            if (n >= 1) begin
                r = vecs[i].sel ? q1[0] : q0[0];
                check($sformatf("vec%0d data", i), 32'(r.data), 32'(vecs[i].exp_d));
                check($sformatf("vec%0d parity_err", i), 32'(r.perr), 32'(vecs[i].exp_perr));
                check($sformatf("vec%0d frame_err", i), 32'(r.ferr), 32'(vecs[i].exp_ferr));
                check($sformatf("vec%0d latency", i), r.cyc - t0, vecs[i].exp_lat);
            end
            check($sformatf("vec%0d busy after", i), 32'(vecs[i].sel ? busy1 : busy0), 32'h0);
        end

        // False start: 5 low cycles, then idle.
        q0.delete();
        line0 = 1'b0;
        repeat (4) @(negedge clk);
        check("false start busy rise", 32'(busy0), 32'h1);
        @(negedge clk);
        line0 = 1'b1;
        repeat (12) @(negedge clk);
        check("false start busy low", 32'(busy0), 32'h0);
        repeat (200) @(negedge clk);
        check("false start no valid", q0.size(), 32'd0);
        check("false start data held", 32'(dout0), 32'h01);

        // Framing error: stop bit low, line held low 50 cycles from the stop bit.
        q0.delete();
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
        check("break busy held", 32'(busy0), 32'h1);
        repeat (30) @(negedge clk);
        check("break busy still", 32'(busy0), 32'h1);
        line0 = 1'b1;
        repeat (10) @(negedge clk);
        check("break busy released", 32'(busy0), 32'h0);
        check("break valid count", q0.size(), 32'd1);
        if (q0.size() >= 1) begin
            check("break data", 32'(q0[0].data), 32'h3C);
            check("break frame_err", 32'(q0[0].ferr), 32'h1);
            check("break parity_err", 32'(q0[0].perr), 32'h0);
        end
        check("frame_err held", 32'(ferr0), 32'h1);

        // Reset during data bit 4 of 0xF0; bits 4..7 and stop are high, so no stray edge follows.
        q0.delete();
        drive_bit(1'b0, 1'b0, 5 * C);
        line0 = 1'b1;
        repeat (10) @(negedge clk);
        check("pre-reset busy", 32'(busy0), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("mid reset data_out", 32'(dout0), 32'h0);
        check("mid reset frame_err", 32'(ferr0), 32'h0);
        check("mid reset data_valid", 32'(dv0), 32'h0);
        check("mid reset parity_err", 32'(perr0), 32'h0);
        check("mid reset busy", 32'(busy0), 32'h0);
        check("mid reset data_out par", 32'(dout1), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (150) @(negedge clk);
        check("aborted frame no valid", q0.size(), 32'd0);
        t0 = cyc;
        send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        check("post reset valid count", q0.size(), 32'd1);
        if (q0.size() >= 1) begin
            check("post reset data", 32'(q0[0].data), 32'h5A);
            check("post reset frame_err", 32'(q0[0].ferr), 32'h0);
            check("post reset latency", q0[0].cyc - t0, 32'd193);
        end

        // Back-to-back frames without an idle gap.
        q0.delete();
        send_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        send_frame(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);
        send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        check("b2b valid count", q0.size(), 32'd3);
        if (q0.size() >= 3) begin
            check("b2b data0", 32'(q0[0].data), 32'h00);
            check("b2b data1", 32'(q0[1].data), 32'hFF);
            check("b2b data2", 32'(q0[2].data), 32'h81);
            check("b2b gap01", q0[1].cyc - q0[0].cyc, 32'd200);
            check("b2b gap12", q0[2].cyc - q0[1].cyc, 32'd200);
        end
        check("b2b busy after", 32'(busy0), 32'h0);

        check("single-cycle pulses", 32'(dbl0), 32'd0);
        check("single-cycle pulses par", 32'(dbl1), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
